cci_fault_inject_afu: RTL
=========================

# cci_fault_inject_afu

Parametrised CCI test AFU for ASE regression: after link init it issues a configurable burst of read or write requests on the CCI TX channels, counts responses, and can inject one deliberate protocol fault at a chosen request index. It replaces single-shot ad-hoc rule-checker AFUs. It sits in place of `cci_std_afu` in ASE regression testbenches, and ASE's checker is expected to flag the injected faults.

## Interface
Parameters:
- `NUM_REQ`, 16: requests issued per run, range 1..16383.
- `MODE`, 0: 0 = clean reads (C0), 1 = clean writes (C1), 2 = X/Z header at `INJECT_AT`, 3 = issue at `INJECT_AT` while AlmFull is high.
- `INJECT_AT`, 8: request index of the fault in modes 2/3; must be less than `NUM_REQ`.
- `START_DELAY`, 18: clocks from InitDn rise to first request.
- `BASE_ADDR`, 32'h0000_1000: line address of request 0.
- `TIMEOUT`, 4096: clocks allowed in DRAIN before error.

Ports. Clock is `vl_clk_LPdomain_32ui`; reset is synchronous, active-low, `ffs_vl_LP32ui_lp2sy_Reset_n`.
- `vl_clk_LPdomain_32ui` in 1: clock.
- `ffs_vl_LP32ui_lp2sy_Reset_n` in 1: sync active-low reset.
- `ffs_vl_LP32ui_lp2sy_InitDnForSys` in 1: link ready.
- `ffs_vl_LP32ui_lp2sy_C0TxAlmFull`, `ffs_vl_LP32ui_lp2sy_C1TxAlmFull` in 1 each: TX flow control.
- `ffs_vl18_LP32ui_lp2sy_C0RxHdr` in 18: RX header.
- `ffs_vl512_LP32ui_lp2sy_C0RxData` in 512: RX data.
- `ffs_vl_LP32ui_lp2sy_C0Rx{Wr,Rd,Cg,Ug,Ir}Valid` in 1 each: RX valids.
- `ffs_vl18_LP32ui_lp2sy_C1RxHdr` in 18: RX header.
- `ffs_vl_LP32ui_lp2sy_C1Rx{Wr,Ir}Valid` in 1 each: RX valids.
- `ffs_vl61_LP32ui_sy2lp_C0TxHdr` out 61: read request header.
- `ffs_vl_LP32ui_sy2lp_C0TxRdValid` out 1: read request valid.
- `ffs_vl61_LP32ui_sy2lp_C1TxHdr` out 61: write request header.
- `ffs_vl512_LP32ui_sy2lp_C1TxData` out 512: write data.
- `ffs_vl_LP32ui_sy2lp_C1TxWrValid`, `ffs_vl_LP32ui_sy2lp_C1TxIrValid` out 1 each: write / interrupt valid.
- `test_done` out 1: run finished (sticky).
- `test_error` out 1: timeout occurred (sticky).

## Operation
- Header layout:
  - [55:52] request type: 4'h4 RdLine, 4'h2 WrLine.
  - [45:14] line address = `BASE_ADDR` + idx.
  - [13:0] mdata = idx.
  - All other bits 0.
- Write data is {16{idx zero-extended to 32b}}. `C1TxIrValid` is always 0.
- FSM states:
  - IDLE: go to DELAY when InitDn is 1.
  - DELAY: count `START_DELAY` clocks, then go to ISSUE.
  - ISSUE: go to DRAIN after request `NUM_REQ`-1 is issued.
  - DRAIN: go to DONE when resp_cnt == `NUM_REQ`, or to DONE with `test_error`=1 when the drain counter reaches `TIMEOUT`.
  - DONE: terminal until reset.
- ISSUE rules:
  - Each cycle, if the active channel's AlmFull (C0 for mode 0/2/3 reads, C1 for mode 1) sampled this cycle is 0, register one request with valid=1 for the next cycle and increment idx.
  - Otherwise valid=0 and idx holds.
- Mode 2: at idx == `INJECT_AT` the header is driven to 61'hxZxx_xxxx_xxxx_xxxx with valid=1; the request still counts. This is simulation-only and not synthesisable intent.
- Mode 3: at idx == `INJECT_AT` the request issues regardless of AlmFull. All other indices obey AlmFull.
- Response counting:
  - Mode 0/2/3: +1 per C0RxRdValid.
  - Mode 1: +1 per C0RxWrValid plus +1 per C1RxWrValid.
  - Both write valids in the same cycle add +2.
  - Responses are counted in every state except IDLE. resp_cnt saturates at `NUM_REQ`.
- Reset mid-run: all state returns to IDLE at the next clock edge. Outstanding responses arriving after reset are ignored until DELAY is entered.
- In modes 2/3, DRAIN timeout is an expected outcome; `test_error` simply reports it.

## Timing
- Reset values: all TX hdr/data 0, all TX valids 0, `test_done` 0, `test_error` 0, idx 0, resp_cnt 0, state IDLE.
- First valid appears exactly `START_DELAY`+1 clocks after InitDn is first sampled high, provided AlmFull is 0.
- Valid is a single-cycle pulse per request. With AlmFull held 0 the issue rate is one request per clock, so `NUM_REQ` requests occupy `NUM_REQ` consecutive clocks.
- AlmFull→valid latency is 1 clock: a request registered in the cycle AlmFull rises is still issued.
- `test_done` rises one clock after the DRAIN exit condition is met.

## Structure
- Package `cci_test_pkg` holds:
  - request type constants;
  - header field offsets;
  - `mode_e` {CLEAN_RD, CLEAN_WR, INJ_X, INJ_ALMFULL};
  - `state_e` {IDLE, DELAY, ISSUE, DRAIN, DONE};
  - function `pack_hdr(type, addr, mdata)`.
- Sub-module `cci_test_resp_counter`: counts RX valids (0/1/2 per cycle) with saturation and owns the DRAIN timeout counter. Outputs are `all_rcvd` and `timed_out`.

## Test plan
- Clean read, `MODE`=0, `NUM_REQ`=16, ASE BFM echoing every read: 16 C0TxRdValid pulses with mdata 0..15 and addresses 0x1000..0x100F; `test_done`=1, `test_error`=0.
- Backpressure, `MODE`=0: hold C0TxAlmFull=1 for clocks 3..10 of ISSUE. No valid for 8 clocks starting one clock after assertion, and no request is lost (all 16 mdata values present).
- Clean write, `MODE`=1, `NUM_REQ`=4: data word 0 of write idx 2 is 32'h2. Responses 2 on C0 and 2 on C1, with one C0/C1 pair in the same cycle: resp_cnt reaches 4 and `test_done`=1.
- X inject, `MODE`=2, `INJECT_AT`=8: request 8's header contains X/Z, the ASE checker reports an error, requests 9..15 are still issued, and on timeout `test_error`=1.
- Reset mid-run: deassert Reset_n for one clock during ISSUE at idx 5. All outputs return to reset values, then the run restarts from idx 0 after `START_DELAY`.

Source files
------------

// File: rtl/cci_test_pkg.sv
// Shared types, header field layout and header packing for the CCI fault-inject test AFU.
// No logic of its own: constants, enums and a pure header-builder function.
package cci_test_pkg;

    localparam logic [3:0] REQ_RD_LINE = 4'h4;
    localparam logic [3:0] REQ_WR_LINE = 4'h2;

    localparam int HDR_W         = 61;
    localparam int HDR_TYPE_LSB  = 52;
    localparam int HDR_ADDR_LSB  = 14;
    localparam int HDR_MDATA_LSB = 0;
    localparam int IDX_W         = 14;

    // Deliberately unknown header used to provoke the downstream protocol checker.
    localparam logic [HDR_W-1:0] HDR_XZ = {1'bx, 4'bz, 56'bx};

    typedef enum logic [1:0] {
        CLEAN_RD    = 2'd0,
        CLEAN_WR    = 2'd1,
        INJ_X       = 2'd2,
        INJ_ALMFULL = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic logic [HDR_W-1:0] pack_hdr(
        input logic [3:0]       req_type,
        input logic [31:0]      addr,
        input logic [IDX_W-1:0] mdata
    );
        logic [HDR_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_TYPE_LSB +: 4]      = req_type;
        hdr[HDR_ADDR_LSB +: 32]     = addr;
        hdr[HDR_MDATA_LSB +: IDX_W] = mdata;
        return hdr;
    endfunction

endpackage

// File: rtl/cci_test_resp_counter.sv
// Counts 0/1/2 responses per clock saturating at NUM_REQ, and times the drain phase.
// Latency: counts land one clock after the RX valids; no backpressure, every valid is consumed.
module cci_test_resp_counter #(
    parameter int NUM_REQ = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic drain,
    input  logic wr_mode,
    input  logic rd_vld,
    input  logic c0_wr_vld,
    input  logic c1_wr_vld,
    output logic all_rcvd,
    output logic timed_out
);

    localparam int CNT_W = $clog2(NUM_REQ + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_REQ);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    logic [CNT_W-1:0] resp_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;

    always_comb begin
        inc = 2'd0;
        if (wr_mode) begin
            inc = {1'b0, c0_wr_vld} + {1'b0, c1_wr_vld};
        end else begin
            inc = {1'b0, rd_vld};
        end
        sum = {1'b0, resp_cnt} + (CNT_W+1)'(inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            resp_cnt <= '0;
        end else if (sum >= {1'b0, CNT_MAX}) begin
            resp_cnt <= CNT_MAX;
        end else begin
            resp_cnt <= sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            tmo_cnt <= '0;
        end else if (drain && !timed_out) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign all_rcvd  = (resp_cnt == CNT_MAX);
    assign timed_out = (tmo_cnt == TMO_MAX);

endmodule

// File: rtl/cci_fault_inject_afu.sv
// CCI test AFU: after InitDn waits START_DELAY, issues NUM_REQ reads or writes, optionally faulting one.
// Latency: first valid START_DELAY+1 clocks after InitDn; AlmFull stalls issue with 1-clock lag.
module cci_fault_inject_afu
    import cci_test_pkg::*;
#(
    parameter int          NUM_REQ     = 16,
    parameter int          MODE        = 0,
    parameter int          INJECT_AT   = 8,
    parameter int          START_DELAY = 18,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          TIMEOUT     = 4096
) (
    input  logic         vl_clk_LPdomain_32ui,
    input  logic         ffs_vl_LP32ui_lp2sy_Reset_n,
    input  logic         ffs_vl_LP32ui_lp2sy_InitDnForSys,
    input  logic         ffs_vl_LP32ui_lp2sy_C0TxAlmFull,
    input  logic         ffs_vl_LP32ui_lp2sy_C1TxAlmFull,
    input  logic [17:0]  ffs_vl18_LP32ui_lp2sy_C0RxHdr,
    input  logic [511:0] ffs_vl512_LP32ui_lp2sy_C0RxData,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxWrValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxRdValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxCgValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxUgValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C0RxIrValid,
    input  logic [17:0]  ffs_vl18_LP32ui_lp2sy_C1RxHdr,
    input  logic         ffs_vl_LP32ui_lp2sy_C1RxWrValid,
    input  logic         ffs_vl_LP32ui_lp2sy_C1RxIrValid,
    output logic [60:0]  ffs_vl61_LP32ui_sy2lp_C0TxHdr,
    output logic         ffs_vl_LP32ui_sy2lp_C0TxRdValid,
    output logic [60:0]  ffs_vl61_LP32ui_sy2lp_C1TxHdr,
    output logic [511:0] ffs_vl512_LP32ui_sy2lp_C1TxData,
    output logic         ffs_vl_LP32ui_sy2lp_C1TxWrValid,
    output logic         ffs_vl_LP32ui_sy2lp_C1TxIrValid,
    output logic         test_done,
    output logic         test_error
);

    localparam mode_e MODE_E  = mode_e'(MODE[1:0]);
    localparam bit    WR_MODE = (MODE_E == CLEAN_WR);
    localparam int    DLY_W   = $clog2(START_DELAY + 2);

    logic clk;
    logic rst_n;
    assign clk   = vl_clk_LPdomain_32ui;
    assign rst_n = ffs_vl_LP32ui_lp2sy_Reset_n;

    state_e           state;
    state_e           next_state;
    logic [IDX_W-1:0] idx;
    logic [DLY_W-1:0] dly_cnt;
    logic             dly_done;
    logic             alm_full;
    logic             inject_here;
    logic             last_req;
    logic             issue;
    logic             drain_exit;
    logic [HDR_W-1:0] req_hdr;
    logic             all_rcvd;
    logic             timed_out;

    assign alm_full    = WR_MODE ? ffs_vl_LP32ui_lp2sy_C1TxAlmFull : ffs_vl_LP32ui_lp2sy_C0TxAlmFull;
    assign inject_here = (idx == IDX_W'(INJECT_AT));
    assign last_req    = (idx == IDX_W'(NUM_REQ - 1));
    assign dly_done    = (int'(dly_cnt) + 1 >= START_DELAY);

    // The AlmFull-override fault pushes its one request through regardless of flow control.
    assign issue = (state == ISSUE) &&
                   (!alm_full || ((MODE_E == INJ_ALMFULL) && inject_here));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        drain_exit = 1'b0;
        case (state)
            IDLE: begin
                if (ffs_vl_LP32ui_lp2sy_InitDnForSys) begin
                    next_state = DELAY;
                end
            end
            DELAY: begin
                if (dly_done) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (issue && last_req) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (all_rcvd || timed_out) begin
                    drain_exit = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (state != DELAY)) begin
            dly_cnt <= '0;
        end else begin
            dly_cnt <= dly_cnt + 1'b1;
        end
    end

    always_comb begin
        req_hdr = pack_hdr(WR_MODE ? REQ_WR_LINE : REQ_RD_LINE,
                           BASE_ADDR + 32'(idx), idx);
        if ((MODE_E == INJ_X) && inject_here) begin
            req_hdr = HDR_XZ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx                             <= '0;
            ffs_vl61_LP32ui_sy2lp_C0TxHdr   <= '0;
            ffs_vl_LP32ui_sy2lp_C0TxRdValid <= 1'b0;
            ffs_vl61_LP32ui_sy2lp_C1TxHdr   <= '0;
            ffs_vl512_LP32ui_sy2lp_C1TxData <= '0;
            ffs_vl_LP32ui_sy2lp_C1TxWrValid <= 1'b0;
        end else begin
            ffs_vl_LP32ui_sy2lp_C0TxRdValid <= issue && !WR_MODE;
            ffs_vl_LP32ui_sy2lp_C1TxWrValid <= issue && WR_MODE;
            if (issue) begin
                idx <= idx + 1'b1;
                if (WR_MODE) begin
                    ffs_vl61_LP32ui_sy2lp_C1TxHdr   <= req_hdr;
                    ffs_vl512_LP32ui_sy2lp_C1TxData <= {16{32'(idx)}};
                end else begin
                    ffs_vl61_LP32ui_sy2lp_C0TxHdr <= req_hdr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            test_done  <= 1'b0;
            test_error <= 1'b0;
        end else if (drain_exit) begin
            test_done  <= 1'b1;
            test_error <= !all_rcvd;
        end
    end

    assign ffs_vl_LP32ui_sy2lp_C1TxIrValid = 1'b0;

    // Responses that straggle in after a reset are dropped while parked in IDLE.
    cci_test_resp_counter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) u_resp_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == IDLE),
        .drain     (state == DRAIN),
        .wr_mode   (WR_MODE),
        .rd_vld    (ffs_vl_LP32ui_lp2sy_C0RxRdValid),
        .c0_wr_vld (ffs_vl_LP32ui_lp2sy_C0RxWrValid),
        .c1_wr_vld (ffs_vl_LP32ui_lp2sy_C1RxWrValid),
        .all_rcvd  (all_rcvd),
        .timed_out (timed_out)
    );

    logic unused_inputs;
    assign unused_inputs = ^{ffs_vl18_LP32ui_lp2sy_C0RxHdr, ffs_vl512_LP32ui_lp2sy_C0RxData,
                             ffs_vl_LP32ui_lp2sy_C0RxCgValid, ffs_vl_LP32ui_lp2sy_C0RxUgValid,
                             ffs_vl_LP32ui_lp2sy_C0RxIrValid, ffs_vl18_LP32ui_lp2sy_C1RxHdr,
                             ffs_vl_LP32ui_lp2sy_C1RxIrValid};

endmodule
